// File: rtl/nios_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words after a start pulse
// and compares them against build-time expected values, flagging mismatches and bus timeouts.
module nios_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hE097CBDC,
    parameter logic [31:0] EXPECTED_TS    = 32'h57628448,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_ID  = 3'd1,
        S_WAIT_ID = 3'd2,
        S_REQ_TS  = 3'd3,
        S_WAIT_TS = 3'd4,
        S_FIN     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    // Last counter value a transaction may reach before it is declared dead.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    function automatic logic word_eq(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

    state_t      r_state;
    logic [15:0] r_tmo_cnt;
    logic        r_avm_address;
    logic        r_avm_read;
    logic        r_busy;
    logic        r_done;
    logic        r_id_match;
    logic        r_ts_match;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic w_in_req;
    logic w_in_wait;
    logic w_accept;
    logic w_capture;
    logic w_expired;

    assign w_in_req  = (r_state == S_REQ_ID)  || (r_state == S_REQ_TS);
    assign w_in_wait = (r_state == S_WAIT_ID) || (r_state == S_WAIT_TS);
    assign w_accept  = r_avm_read & ~avm_waitrequest;
    // A zero-latency slave may return data on the very edge that accepts the command.
    assign w_capture = (w_in_req & w_accept & avm_readdatavalid) |
                       (w_in_wait & avm_readdatavalid);
    assign w_expired = (w_in_req | w_in_wait) && (r_tmo_cnt == TMO_LAST);

    // Sequencer: issues the two reads, captures/compares data and tracks the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tmo_cnt     <= 16'd0;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= 32'd0;
            r_ts_value    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state       <= S_REQ_ID;
                        r_tmo_cnt     <= 16'd0;
                        r_avm_address <= 1'b0;
                        r_avm_read    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_id_match    <= 1'b0;
                        r_ts_match    <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_id_value    <= 32'd0;
                        r_ts_value    <= 32'd0;
                    end
                end
                S_REQ_ID, S_WAIT_ID: begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    if (w_capture) begin
                        r_id_value    <= avm_readdata;
                        r_id_match    <= word_eq(avm_readdata, EXPECTED_ID);
                        r_state       <= S_REQ_TS;
                        r_tmo_cnt     <= 16'd0;
                        r_avm_address <= 1'b1;
                        r_avm_read    <= 1'b1;
                    end else if (w_expired) begin
                        r_state    <= S_ERR;
                        r_avm_read <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_done     <= 1'b1;
                    end else if (w_in_req && w_accept) begin
                        r_state    <= S_WAIT_ID;
                        r_avm_read <= 1'b0;
                    end
                end
                S_REQ_TS, S_WAIT_TS: begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    if (w_capture) begin
                        r_ts_value <= avm_readdata;
                        r_ts_match <= word_eq(avm_readdata, EXPECTED_TS);
                        r_state    <= S_FIN;
                        r_avm_read <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (w_expired) begin
                        r_state    <= S_ERR;
                        r_avm_read <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_done     <= 1'b1;
                    end else if (w_in_req && w_accept) begin
                        r_state    <= S_WAIT_TS;
                        r_avm_read <= 1'b0;
                    end
                end
                S_FIN, S_ERR: begin
                    r_state       <= S_IDLE;
                    r_done        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_avm_read    <= 1'b0;
                    r_avm_address <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_tmo_cnt     <= 16'd0;
                    r_avm_address <= 1'b0;
                    r_avm_read    <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address = r_avm_address;
    assign avm_read    = r_avm_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_match    = r_id_match;
    assign ts_match    = r_ts_match;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Scoreboard bench for nios_sysid_checker: behavioural Avalon slave, directed sequences,
// expected results queued at stimulus time and checked by a monitor on each done pulse.
module tb_nios_sysid_checker;

    localparam logic [31:0] EID = 32'hE097CBDC;
    localparam logic [31:0] ETS = 32'h57628448;

    logic        clock;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    nios_sysid_checker #(
        .EXPECTED_ID   (EID),
        .EXPECTED_TS   (ETS),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .id_match         (id_match),
        .ts_match         (ts_match),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value)
    );

    typedef struct packed {
        logic        idm;
        logic        tsm;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   ts_start_cyc = 0;
    bit   ts_seen = 0;

    // slave configuration and log
    int          cfg_wait = 0;
    int          cfg_lat = 0;
    logic [31:0] cfg_id = 32'd0;
    logic [31:0] cfg_ts = 32'd0;
    bit          cfg_no_ts = 0;
    int          accepts = 0;
    logic        addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Slave model: programmable stall count and read latency.
    initial begin
        int          stall;
        int          pend;
        bit          pend_ok;
        logic [31:0] pend_data;
        bit          ok;
        logic [31:0] d;
        stall = 0; pend = 0; pend_ok = 0; pend_data = 32'd0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
        forever begin
            @(posedge clock); #1;
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && pend_ok) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = pend_data;
                end
            end
            if (avm_read) begin
                if (stall < cfg_wait) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                end else begin
                    stall = 0;
                    accepts++;
                    addr_log.push_back(avm_address);
                    ok = !(cfg_no_ts && avm_address);
                    d = avm_address ? cfg_ts : cfg_id;
                    if (cfg_lat == 0) begin
                        if (ok) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata = d;
                        end
                    end else begin
                        pend = cfg_lat;
                        pend_ok = ok;
                        pend_data = d;
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pop on done, stall stability, TS-phase start time.
    initial begin
        exp_t e;
        bit   prev_stall;
        logic prev_addr;
        prev_stall = 0; prev_addr = 1'b0;
        forever begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_match", {31'd0, id_match}, {31'd0, e.idm});
                    chk("ts_match", {31'd0, ts_match}, {31'd0, e.tsm});
                    chk("timeout", {31'd0, timeout}, {31'd0, e.tmo});
                    chk("id_value", id_value, e.idv);
                    chk("ts_value", ts_value, e.tsv);
                end
            end
            if (prev_stall && !reset) begin
                chk("stall_read_held", {31'd0, avm_read}, 32'd1);
                chk("stall_addr_held", {31'd0, avm_address}, {31'd0, prev_addr});
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            if (avm_read && avm_address && !ts_seen) begin
                ts_seen = 1;
                ts_start_cyc = cyc;
            end
        end
    end

    // mode: 0 none, 1 check start->done latency, 2 check TS-phase length before ERR
    task automatic run_seq(input exp_t e, input int w, input int lat, input logic [31:0] idd,
                           input logic [31:0] tsd, input bit no_ts, input bit repulse,
                           input int mode, input int exp_cycles);
        int d0;
        int st_cyc;
        cfg_wait = w; cfg_lat = lat; cfg_id = idd; cfg_ts = tsd; cfg_no_ts = no_ts;
        accepts = 0;
        addr_log.delete();
        ts_seen = 0;
        exp_q.push_back(e);
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b1;
        st_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        if (repulse) begin
            @(posedge clock); #1;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clock);
        if (done_cnt == d0) begin
            chk("done_seen", 32'd0, 32'd1);
        end else begin
            if (mode == 1) chk("start_to_done", 32'(done_cyc - st_cyc), 32'(exp_cycles));
            if (mode == 2) chk("ts_phase_len", 32'(done_cyc - ts_start_cyc), 32'(exp_cycles));
        end
        @(negedge clock);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("read_count", 32'(accepts), 32'd2);
        if (addr_log.size() == 2) begin
            chk("addr_first", {31'd0, addr_log[0]}, 32'd0);
            chk("addr_second", {31'd0, addr_log[1]}, 32'd1);
        end else begin
            chk("addr_log_size", 32'(addr_log.size()), 32'd2);
        end
        repeat (3) @(posedge clock);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_addr", {31'd0, avm_address}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {29'd0, id_match, ts_match, timeout}, 32'd0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: matching image, zero-wait zero-latency slave
        run_seq('{1'b1, 1'b1, 1'b0, EID, ETS}, 0, 0, EID, ETS, 0, 0, 1, 3);
        // 2: wrong ID word
        run_seq('{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, ETS}, 0, 0, 32'hDEADBEEF, ETS, 0, 0, 0, 0);
        // 3: 5-cycle stalls, 3-cycle latency, start re-pulsed while busy
        run_seq('{1'b1, 1'b1, 1'b0, EID, ETS}, 5, 3, EID, ETS, 0, 1, 0, 0);
        // 4: timestamp read never returns data
        run_seq('{1'b1, 1'b0, 1'b1, EID, 32'd0}, 0, 0, EID, ETS, 1, 0, 2, 16);
        // 2b: wrong timestamp only (one bit off)
        run_seq('{1'b1, 1'b0, 1'b0, EID, 32'h57628449}, 0, 1, EID, 32'h57628449, 0, 0, 0, 0);

        // 5: re-pulse during stall, then reset in WAIT_ID with late data
        cfg_wait = 2; cfg_lat = 3; cfg_id = 32'h12345678; cfg_ts = ETS; cfg_no_ts = 0;
        accepts = 0;
        addr_log.delete();
        d0 = done_cnt;
        @(posedge clock); #1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock);
        chk("t5_in_wait_busy", {31'd0, busy}, 32'd1);
        chk("t5_in_wait_read", {31'd0, avm_read}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t5_read_after_rst", {31'd0, avm_read}, 32'd0);
        chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("t5_id_value", id_value, 32'd0);
        chk("t5_flags", {29'd0, id_match, ts_match, timeout}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_read", {31'd0, avm_read}, 32'd0);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_one_read", 32'(accepts), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
